// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single BRAM data port.
// Requester 0 has priority; requester 1 is boosted after MAX_WAIT denials.
module mem_port_arbiter #(
  parameter  int ADDR_W   = 16,
  parameter  int NB_COL   = 4,
  parameter  int COL_W    = 8,
  parameter  int MAX_WAIT = 4,
  localparam int DATA_W   = NB_COL * COL_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_req_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [NB_COL-1:0] m0_we_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  input  logic              m1_req_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [NB_COL-1:0] m1_we_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              mem_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [NB_COL-1:0] mem_we_o,
  output logic [DATA_W-1:0] mem_din_o,
  input  logic [DATA_W-1:0] mem_dout_i
);

  localparam logic [7:0] MaxW = 8'(MAX_WAIT);

  logic [7:0] wait_q, wait_d;
  logic       own_vld_q, own_vld_d;
  logic       own_id_q, own_id_d;
  logic       boost, gnt0, gnt1;

  always_comb begin
    boost = (wait_q == MaxW);
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    if (!rst_i) begin
      priority case (1'b1)
        boost && m1_req_i: gnt1 = 1'b1;
        m0_req_i:          gnt0 = 1'b1;
        m1_req_i:          gnt1 = 1'b1;
        default: ;
      endcase
    end
  end

  assign m0_gnt_o = gnt0;
  assign m1_gnt_o = gnt1;

  // Idle cycles leave address/data on m0 fields; only en/we matter.
  always_comb begin
    mem_en_o   = gnt0 | gnt1;
    mem_addr_o = gnt1 ? m1_addr_i  : m0_addr_i;
    mem_din_o  = gnt1 ? m1_wdata_i : m0_wdata_i;
    mem_we_o   = '0;
    if (gnt1)      mem_we_o = m1_we_i;
    else if (gnt0) mem_we_o = m0_we_i;
  end

  always_comb begin
    wait_d = wait_q;
    if (!m1_req_i || gnt1) wait_d = '0;
    else if (wait_q != MaxW) wait_d = wait_q + 8'd1;
  end

  always_comb begin
    own_vld_d = gnt0 | gnt1;
    own_id_d  = gnt1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_q    <= '0;
      own_vld_q <= 1'b0;
      own_id_q  <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      own_vld_q <= own_vld_d;
      own_id_q  <= own_id_d;
    end
  end

  // A reset arriving with a response in flight suppresses that response.
  assign m0_rvalid_o = own_vld_q & ~own_id_q & ~rst_i;
  assign m1_rvalid_o = own_vld_q &  own_id_q & ~rst_i;
  assign m0_rdata_o  = mem_dout_i;
  assign m1_rdata_o  = mem_dout_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed plan steps then constrained-random
// traffic, checked against a rule-level arbitration and memory model.
module tb_mem_port_arbiter;

  localparam int AW = 16;
  localparam int NB = 4;
  localparam int CW = 8;
  localparam int DW = NB * CW;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          m0_req_i, m1_req_i;
  logic [AW-1:0] m0_addr_i, m1_addr_i;
  logic [NB-1:0] m0_we_i, m1_we_i;
  logic [DW-1:0] m0_wdata_i, m1_wdata_i;
  logic          m0_gnt_o, m1_gnt_o;
  logic          m0_rvalid_o, m1_rvalid_o;
  logic [DW-1:0] m0_rdata_o, m1_rdata_o;
  logic          mem_en_o;
  logic [AW-1:0] mem_addr_o;
  logic [NB-1:0] mem_we_o;
  logic [DW-1:0] mem_din_o;
  logic [DW-1:0] mem_dout_i;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW), .NB_COL(NB), .COL_W(CW), .MAX_WAIT(MW)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i),
    .m0_we_i(m0_we_i), .m0_wdata_i(m0_wdata_i),
    .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o),
    .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i),
    .m1_we_i(m1_we_i), .m1_wdata_i(m1_wdata_i),
    .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o),
    .m1_rdata_o(m1_rdata_o),
    .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o), .mem_din_o(mem_din_o),
    .mem_dout_i(mem_dout_i)
  );

  // Read-first byte-write BRAM environment model.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (mem_en_o) begin
      mem_dout_i <= mem[mem_addr_o[7:0]];
      for (int b = 0; b < NB; b++)
        if (mem_we_o[b])
          mem[mem_addr_o[7:0]][b*CW +: CW] <= mem_din_o[b*CW +: CW];
    end
  end

  // Reference model state.
  logic [DW-1:0] shadow [256];
  int            r_wait;
  int            r_pend;
  logic          r_rd;
  logic [DW-1:0] r_data;
  int            r_g;
  logic          d_g0, d_g1;
  logic [DW-1:0] d_rd0, d_rd1;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive0(logic r, logic [AW-1:0] a,
                        logic [NB-1:0] w, logic [DW-1:0] d);
    m0_req_i = r; m0_addr_i = a; m0_we_i = w; m0_wdata_i = d;
  endtask

  task automatic drive1(logic r, logic [AW-1:0] a,
                        logic [NB-1:0] w, logic [DW-1:0] d);
    m1_req_i = r; m1_addr_i = a; m1_we_i = w; m1_wdata_i = d;
  endtask

  task automatic tick();
    int            g;
    logic [AW-1:0] a;
    logic [NB-1:0] w;
    logic [DW-1:0] d;
    @(negedge clk);
    g = -1;
    if (!rst_i) begin
      if (m1_req_i && r_wait >= MW) g = 1;
      else if (m0_req_i)            g = 0;
      else if (m1_req_i)            g = 1;
    end
    d_g0 = m0_gnt_o; d_g1 = m1_gnt_o;
    d_rd0 = m0_rdata_o; d_rd1 = m1_rdata_o;
    chk("gnt0", 64'(m0_gnt_o), 64'(g == 0));
    chk("gnt1", 64'(m1_gnt_o), 64'(g == 1));
    chk("mem_en", 64'(mem_en_o), 64'(g >= 0));
    chk("rvalid0", 64'(m0_rvalid_o), 64'(!rst_i && r_pend == 0));
    chk("rvalid1", 64'(m1_rvalid_o), 64'(!rst_i && r_pend == 1));
    if (!rst_i && r_pend >= 0 && r_rd)
      chk("rdata", 64'(r_pend == 0 ? m0_rdata_o : m1_rdata_o),
          64'(r_data));
    a = (g == 1) ? m1_addr_i  : m0_addr_i;
    w = (g == 1) ? m1_we_i    : m0_we_i;
    d = (g == 1) ? m1_wdata_i : m0_wdata_i;
    if (g >= 0) begin
      chk("mem_addr", 64'(mem_addr_o), 64'(a));
      chk("mem_we", 64'(mem_we_o), 64'(w));
      chk("mem_din", 64'(mem_din_o), 64'(d));
    end else begin
      chk("mem_we_idle", 64'(mem_we_o), 64'(0));
    end
    @(posedge clk);
    if (rst_i) begin
      r_wait = 0;
      r_pend = -1;
    end else begin
      r_pend = g;
      if (g >= 0) begin
        r_rd   = (w == '0);
        r_data = shadow[a[7:0]];
        for (int b = 0; b < NB; b++)
          if (w[b]) shadow[a[7:0]][b*CW +: CW] = d[b*CW +: CW];
      end
      if (!m1_req_i || g == 1) r_wait = 0;
      else if (r_wait < MW)    r_wait++;
    end
    r_g = g;
    #1;
  endtask

  int c1;
  int n;
  logic a0_req, a1_req;
  logic [AW-1:0] a0_a, a1_a;
  logic [NB-1:0] a0_w, a1_w;
  logic [DW-1:0] a0_d, a1_d;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      shadow[i] = mem[i];
    end
    mem[8'h10] = 32'hDEADBEEF; shadow[8'h10] = 32'hDEADBEEF;
    mem[8'h20] = 32'h11223344; shadow[8'h20] = 32'h11223344;
    mem_dout_i = '0;
    r_wait = 0; r_pend = -1; r_rd = 1'b0; r_data = '0; r_g = -1;
    rst_i = 1'b1;
    drive0(0, 0, 0, 0);
    drive1(0, 0, 0, 0);
    tick();
    drive0(1, 16'h5, 0, 0);
    drive1(1, 16'h6, 0, 0);
    tick();
    rst_i = 1'b0;
    drive0(0, 0, 0, 0);
    drive1(0, 0, 0, 0);
    tick();

    // Single m0 read.
    drive0(1, 16'h0010, 4'b0000, 32'h0);
    tick();
    drive0(0, 16'h0, 4'b0000, 32'h0);
    tick();
    chk("plan_m0_rdata", 64'(d_rd0), 64'(32'hDEADBEEF));

    // m1 byte write then read back.
    drive1(1, 16'h0020, 4'b0010, 32'h0000AB00);
    tick();
    drive1(1, 16'h0020, 4'b0000, 32'h0);
    tick();
    drive1(0, 16'h0, 4'b0000, 32'h0);
    tick();
    chk("plan_m1_byte", 64'(d_rd1), 64'(32'h1122AB44));

    // Full contention for 20 cycles.
    c1 = 0;
    drive0(1, 16'h0030, 4'b0000, 32'h0);
    drive1(1, 16'h0031, 4'b0000, 32'h0);
    for (int i = 0; i < 20; i++) begin
      tick();
      c1 += int'(d_g1);
    end
    chk("plan_m1_grants", 64'(c1), 64'(4));
    drive0(0, 0, 0, 0);
    drive1(0, 0, 0, 0);
    tick();

    // Back-to-back m0 reads.
    for (int i = 1; i <= 3; i++) begin
      drive0(1, AW'(i), 4'b0000, 32'h0);
      tick();
    end
    drive0(0, 0, 0, 0);
    tick();
    tick();

    // Reset right after an m1 read grant.
    drive1(1, 16'h0020, 4'b0000, 32'h0);
    tick();
    rst_i = 1'b1;
    drive0(1, 16'h0040, 4'b0000, 32'h0);
    tick();
    rst_i = 1'b0;
    tick();
    chk("plan_post_rst_m0", 64'(d_g0), 64'(1));
    drive0(0, 0, 0, 0);
    drive1(0, 0, 0, 0);
    tick();
    tick();

    // Dropped m1 request restarts its wait count.
    drive0(1, 16'h0050, 4'b0000, 32'h0);
    drive1(1, 16'h0051, 4'b0000, 32'h0);
    repeat (3) tick();
    drive1(0, 16'h0051, 4'b0000, 32'h0);
    tick();
    drive1(1, 16'h0051, 4'b0000, 32'h0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (d_g1) break;
      n++;
    end
    chk("plan_restart_wait", 64'(n), 64'(4));
    drive0(0, 0, 0, 0);
    drive1(0, 0, 0, 0);
    tick();

    // Random traffic with hold-until-grant requesters.
    a0_req = 0; a1_req = 0;
    a0_a = 0; a1_a = 0; a0_w = 0; a1_w = 0; a0_d = 0; a1_d = 0;
    for (int i = 0; i < 400; i++) begin
      if (!a0_req || r_g == 0) begin
        a0_req = ($urandom_range(0, 3) != 0);
        a0_a   = AW'($urandom_range(0, 15));
        a0_w   = $urandom_range(0, 1) ? 4'(0) : 4'($urandom);
        a0_d   = $urandom;
      end
      if (!a1_req || r_g == 1) begin
        a1_req = ($urandom_range(0, 2) != 0);
        a1_a   = AW'($urandom_range(0, 15));
        a1_w   = $urandom_range(0, 1) ? 4'(0) : 4'($urandom);
        a1_d   = $urandom;
      end
      rst_i = ($urandom_range(0, 59) == 0);
      drive0(a0_req, a0_a, a0_w, a0_d);
      drive1(a1_req, a1_a, a1_w, a1_d);
      tick();
      if (rst_i) r_g = -1;
    end
    rst_i = 1'b0;
    drive0(0, 0, 0, 0);
    drive1(0, 0, 0, 0);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
